execute_ldst_pipe: RTL and testbench

- Memory-access stage directly downstream of the execute load/store decode.
- Captures one decoded access (rw, address, store data, order, load shift, byte mask) and issues it on the data-memory request port.
- For loads, waits for the read response, then aligns and masks the data. Presents the result to writeback with a valid/lock handshake.
- One access in flight; the upstream stage is stalled via oPREV_LOCK while busy.

---
 rtl/execute_ldst_pipe.sv | 222 ++++++++++++++++++++++
 tb/tb_execute_ldst_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_ldst_pipe.sv
// rtl/execute_ldst_pipe.sv - execute-stage memory access pipe (load/store issue, align, retire)
//
// Purpose:
//   Captures one decoded load/store from the execute decode stage and issues
//   it on the data-memory request port. Loads wait for the read response,
//   which is shifted into lane 0 and zero-extended to the access size. Every
//   access retires to writeback through a valid/lock handshake. Only one
//   access is in flight, so the upstream stage is stalled while busy.
//
// Configuration:
//   TIMEOUT  - WAIT/DRAIN cycles before a watchdog fault (0 disables it).
//   LDST_PIPE_MISALIGN_FAULT_EN - when defined, a misaligned half or word
//              access faults at capture and retires without a memory request.
//
// Ports:
//   iCLOCK, inRESET          clock, asynchronous active-low reset
//   iFLUSH                   synchronous pipeline flush
//   iPREV_*  / oPREV_LOCK    decoded access from upstream, stall back to it
//   oDATAIO_* / iDATAIO_*    data-memory request and read response
//   oNEXT_*  / iNEXT_LOCK    retired result to writeback, stall from it
//   oFAULT                   one-cycle fault pulse (watchdog or misalign)

module execute_ldst_pipe #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFLUSH,
  input  logic        iPREV_VALID,
  output logic        oPREV_LOCK,
  input  logic        iPREV_RW,
  input  logic [31:0] iPREV_ADDR,
  input  logic [31:0] iPREV_DATA,
  input  logic [1:0]  iPREV_ORDER,
  input  logic [1:0]  iPREV_SHIFT,
  input  logic [3:0]  iPREV_MASK,
  output logic        oDATAIO_REQ,
  input  logic        iDATAIO_LOCK,
  output logic        oDATAIO_RW,
  output logic [31:0] oDATAIO_ADDR,
  output logic [31:0] oDATAIO_DATA,
  output logic [3:0]  oDATAIO_MASK,
  input  logic        iDATAIO_VALID,
  input  logic [31:0] iDATAIO_DATA,
  output logic        oNEXT_VALID,
  input  logic        iNEXT_LOCK,
  output logic        oNEXT_RW,
  output logic [31:0] oNEXT_DATA,
  output logic        oFAULT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } state_t;

  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [31:0] WD_LAST = TIMEOUT - 1;

  state_t      state;

  // Captured access; the word address is all memory needs.
  logic        cap_rw;
  logic [31:2] cap_addr;
  logic [31:0] cap_data;
  logic [1:0]  cap_order;
  logic [1:0]  cap_shift;
  logic [3:0]  cap_mask;

  logic        next_rw;
  logic [31:0] next_data;
  logic        fault;
  logic [31:0] wd_cnt;

  logic        take;
  logic        misalign;
  logic        wd_hit;
  logic [31:0] shifted;
  logic [31:0] aligned;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^iPREV_ADDR[1:0];

`ifdef LDST_PIPE_MISALIGN_FAULT_EN
  assign misalign = ((iPREV_ORDER == 2'd1) && iPREV_ADDR[0]) ||
                    ((iPREV_ORDER == 2'd2) && (iPREV_ADDR[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // A new access is taken from IDLE, or straight out of DONE once writeback
  // accepts the current result, so back-to-back accesses skip the IDLE bubble.
  always_comb begin
    take = 1'b0;
    if (!iFLUSH && iPREV_VALID) begin
      if (state == ST_IDLE)
        take = 1'b1;
      else if (state == ST_DONE && !iNEXT_LOCK)
        take = 1'b1;
    end
  end

  assign wd_hit = WD_EN && (wd_cnt == WD_LAST);

  // Load alignment: shift the addressed lane down, then zero-extend by size.
  always_comb begin
    shifted = iDATAIO_DATA >> {cap_shift, 3'b000};
    case (cap_order)
      2'd0:    aligned = {24'h0, shifted[7:0]};
      2'd1:    aligned = {16'h0, shifted[15:0]};
      default: aligned = shifted;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state     <= ST_IDLE;
      cap_rw    <= 1'b0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_order <= '0;
      cap_shift <= '0;
      cap_mask  <= '0;
      next_rw   <= 1'b0;
      next_data <= '0;
      fault     <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      fault <= 1'b0;
      case (state)
        ST_IDLE: ;
        ST_REQ: begin
          if (!iDATAIO_LOCK) begin
            wd_cnt <= '0;
            if (iFLUSH)
              // An accepted store cannot be recalled and has no response;
              // an accepted load still owes one that must be swallowed.
              state <= cap_rw ? ST_IDLE : ST_DRAIN;
            else if (cap_rw) begin
              next_rw   <= 1'b1;
              next_data <= '0;
              state     <= ST_DONE;
            end else
              state <= ST_WAIT;
          end else if (iFLUSH)
            state <= ST_IDLE;
        end
        ST_WAIT: begin
          if (iDATAIO_VALID) begin
            if (iFLUSH)
              state <= ST_IDLE;
            else begin
              next_rw   <= 1'b0;
              next_data <= aligned;
              state     <= ST_DONE;
            end
          end else if (wd_hit) begin
            fault <= 1'b1;
            state <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
            if (iFLUSH)
              state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (iFLUSH || !iNEXT_LOCK)
            state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (iDATAIO_VALID)
            state <= ST_IDLE;
          else if (wd_hit) begin
            fault <= 1'b1;
            state <= ST_IDLE;
          end else
            wd_cnt <= wd_cnt + 32'd1;
        end
        default: state <= ST_IDLE;
      endcase

      // Capture overrides the state decision above (IDLE or released DONE).
      if (take) begin
        cap_rw    <= iPREV_RW;
        cap_addr  <= iPREV_ADDR[31:2];
        cap_data  <= iPREV_DATA;
        cap_order <= iPREV_ORDER;
        cap_shift <= iPREV_SHIFT;
        cap_mask  <= iPREV_MASK;
        if (misalign) begin
          fault     <= 1'b1;
          next_rw   <= iPREV_RW;
          next_data <= '0;
          state     <= ST_DONE;
        end else
          state <= ST_REQ;
      end
    end
  end

  always_comb begin
    case (state)
      ST_IDLE: oPREV_LOCK = 1'b0;
      ST_DONE: oPREV_LOCK = iNEXT_LOCK;
      default: oPREV_LOCK = 1'b1;
    endcase
  end

  assign oDATAIO_REQ  = (state == ST_REQ);
  assign oDATAIO_RW   = cap_rw;
  assign oDATAIO_ADDR = {cap_addr, 2'b00};
  assign oDATAIO_DATA = cap_data;
  assign oDATAIO_MASK = cap_mask;
  assign oNEXT_VALID  = (state == ST_DONE);
  assign oNEXT_RW     = next_rw;
  assign oNEXT_DATA   = next_data;
  assign oFAULT       = fault;

endmodule

// File: tb/tb_execute_ldst_pipe.sv
// tb/tb_execute_ldst_pipe.sv - self-checking bench for execute_ldst_pipe
module tb_execute_ldst_pipe;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iFLUSH;
  logic        iPREV_VALID;
  logic        oPREV_LOCK;
  logic        iPREV_RW;
  logic [31:0] iPREV_ADDR;
  logic [31:0] iPREV_DATA;
  logic [1:0]  iPREV_ORDER;
  logic [1:0]  iPREV_SHIFT;
  logic [3:0]  iPREV_MASK;
  logic        oDATAIO_REQ;
  logic        iDATAIO_LOCK;
  logic        oDATAIO_RW;
  logic [31:0] oDATAIO_ADDR;
  logic [31:0] oDATAIO_DATA;
  logic [3:0]  oDATAIO_MASK;
  logic        iDATAIO_VALID;
  logic [31:0] iDATAIO_DATA;
  logic        oNEXT_VALID;
  logic        iNEXT_LOCK;
  logic        oNEXT_RW;
  logic [31:0] oNEXT_DATA;
  logic        oFAULT;

  execute_ldst_pipe #(.TIMEOUT(4)) dut (
    .iCLOCK        (iCLOCK),
    .inRESET       (inRESET),
    .iFLUSH        (iFLUSH),
    .iPREV_VALID   (iPREV_VALID),
    .oPREV_LOCK    (oPREV_LOCK),
    .iPREV_RW      (iPREV_RW),
    .iPREV_ADDR    (iPREV_ADDR),
    .iPREV_DATA    (iPREV_DATA),
    .iPREV_ORDER   (iPREV_ORDER),
    .iPREV_SHIFT   (iPREV_SHIFT),
    .iPREV_MASK    (iPREV_MASK),
    .oDATAIO_REQ   (oDATAIO_REQ),
    .iDATAIO_LOCK  (iDATAIO_LOCK),
    .oDATAIO_RW    (oDATAIO_RW),
    .oDATAIO_ADDR  (oDATAIO_ADDR),
    .oDATAIO_DATA  (oDATAIO_DATA),
    .oDATAIO_MASK  (oDATAIO_MASK),
    .iDATAIO_VALID (iDATAIO_VALID),
    .iDATAIO_DATA  (iDATAIO_DATA),
    .oNEXT_VALID   (oNEXT_VALID),
    .iNEXT_LOCK    (iNEXT_LOCK),
    .oNEXT_RW      (oNEXT_RW),
    .oNEXT_DATA    (oNEXT_DATA),
    .oFAULT        (oFAULT)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  order;
    logic [1:0]  shift;
    logic [3:0]  mask;
    logic [31:0] rdata;
    int          lat;
    int          lock_cycles;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  int ret_cnt  = 0;

  always @(posedge iCLOCK) begin
    if (oDATAIO_REQ && !iDATAIO_LOCK) req_cnt++;
    if (oNEXT_VALID && !iNEXT_LOCK) ret_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic drive_prev(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] order, input logic [1:0] shift, input logic [3:0] mask);
    iPREV_VALID = 1'b1;
    iPREV_RW    = rw;
    iPREV_ADDR  = addr;
    iPREV_DATA  = data;
    iPREV_ORDER = order;
    iPREV_SHIFT = shift;
    iPREV_MASK  = mask;
  endtask

  // Full single access from IDLE back to IDLE, checked every cycle.
  task automatic run_vec(input vec_t v);
    drive_prev(v.rw, v.addr, v.wdata, v.order, v.shift, v.mask);
    #1;
    chk("idle_prev_lock", oPREV_LOCK, 0);
    cyc();
    iPREV_VALID = 1'b0;
    for (int k = 0; k <= v.lock_cycles; k++) begin
      iDATAIO_LOCK = (k < v.lock_cycles);
      #1;
      chk("req_valid", oDATAIO_REQ, 1);
      chk("req_addr", oDATAIO_ADDR, v.exp_addr);
      chk("req_data", oDATAIO_DATA, v.wdata);
      chk("req_rw_mask", {oDATAIO_RW, oDATAIO_MASK}, {v.rw, v.mask});
      chk("req_prev_lock", oPREV_LOCK, 1);
      cyc();
    end
    iDATAIO_LOCK = 1'b0;
    if (!v.rw) begin
      for (int w = 1; w <= v.lat; w++) begin
        iDATAIO_VALID = (w == v.lat);
        iDATAIO_DATA  = (w == v.lat) ? v.rdata : ~v.rdata;
        #1;
        chk("wait_next_valid", oNEXT_VALID, 0);
        chk("wait_req", oDATAIO_REQ, 0);
        cyc();
      end
      iDATAIO_VALID = 1'b0;
    end
    #1;
    chk("done_valid", oNEXT_VALID, 1);
    chk("done_rw", oNEXT_RW, v.rw);
    chk("done_data", oNEXT_DATA, v.exp_next);
    cyc();
    chk("retire_idle_valid", oNEXT_VALID, 0);
    chk("retire_idle_lock", oPREV_LOCK, 0);
  endtask

  vec_t vecs[8];
  int   base;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1003, 32'h0, 2'd0, 2'd3, 4'b1000, 32'hAABB_CCDD, 2, 0, 32'h0000_1000, 32'h0000_00AA};
    vecs[1] = '{1'b0, 32'h0000_1002, 32'h0, 2'd1, 2'd2, 4'b1100, 32'hAABB_CCDD, 1, 0, 32'h0000_1000, 32'h0000_AABB};
    vecs[2] = '{1'b0, 32'h0000_2001, 32'h0, 2'd0, 2'd1, 4'b0010, 32'h1122_3344, 1, 0, 32'h0000_2000, 32'h0000_0033};
    vecs[3] = '{1'b0, 32'h0000_2000, 32'h0, 2'd1, 2'd0, 4'b0011, 32'h8899_EEFF, 3, 0, 32'h0000_2000, 32'h0000_EEFF};
    vecs[4] = '{1'b0, 32'h0000_4004, 32'h0, 2'd2, 2'd0, 4'b1111, 32'hDEAD_BEEF, 1, 2, 32'h0000_4004, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 32'h0000_2002, 32'h1234_0000, 2'd1, 2'd2, 4'b1100, 32'h0, 0, 3, 32'h0000_2000, 32'h0};
    vecs[6] = '{1'b1, 32'h0000_5001, 32'h0000_AB00, 2'd0, 2'd1, 4'b0010, 32'h0, 0, 0, 32'h0000_5000, 32'h0};
    vecs[7] = '{1'b1, 32'h0000_6000, 32'hCAFE_F00D, 2'd2, 2'd0, 4'b1111, 32'h0, 0, 1, 32'h0000_6000, 32'h0};

    inRESET = 1'b0;
    iFLUSH = 1'b0;
    iPREV_VALID = 1'b0;
    iPREV_RW = 1'b0;
    iPREV_ADDR = 32'h0;
    iPREV_DATA = 32'h0;
    iPREV_ORDER = 2'd0;
    iPREV_SHIFT = 2'd0;
    iPREV_MASK = 4'h0;
    iDATAIO_LOCK = 1'b0;
    iDATAIO_VALID = 1'b0;
    iDATAIO_DATA = 32'h0;
    iNEXT_LOCK = 1'b0;
    cyc();
    cyc();
    chk("reset_ctl", {oPREV_LOCK, oDATAIO_REQ, oDATAIO_RW, oNEXT_VALID, oNEXT_RW, oFAULT}, 0);
    chk("reset_req_fields", oDATAIO_ADDR | oDATAIO_DATA | {28'h0, oDATAIO_MASK}, 0);
    chk("reset_next_data", oNEXT_DATA, 0);
    inRESET = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-to-back word loads, writeback stalls the first for two cycles.
    base = req_cnt;
    drive_prev(1'b0, 32'h0000_0100, 32'h0, 2'd2, 2'd0, 4'hF);
    cyc();
    iPREV_VALID = 1'b0;
    cyc();
    iDATAIO_VALID = 1'b1;
    iDATAIO_DATA = 32'h1111_1111;
    cyc();
    iDATAIO_VALID = 1'b0;
    iNEXT_LOCK = 1'b1;
    drive_prev(1'b0, 32'h0000_0200, 32'h0, 2'd2, 2'd0, 4'hF);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("b2b_hold_valid", oNEXT_VALID, 1);
      chk("b2b_hold_data", oNEXT_DATA, 32'h1111_1111);
      chk("b2b_hold_prev_lock", oPREV_LOCK, 1);
      chk("b2b_hold_no_req", oDATAIO_REQ, 0);
      cyc();
    end
    iNEXT_LOCK = 1'b0;
    #1;
    chk("b2b_release_prev_lock", oPREV_LOCK, 0);
    chk("b2b_release_data", oNEXT_DATA, 32'h1111_1111);
    cyc();
    iPREV_VALID = 1'b0;
    #1;
    chk("b2b_second_req", oDATAIO_REQ, 1);
    chk("b2b_second_addr", oDATAIO_ADDR, 32'h0000_0200);
    chk("b2b_no_bubble_valid", oNEXT_VALID, 0);
    cyc();
    iDATAIO_VALID = 1'b1;
    iDATAIO_DATA = 32'h2222_2222;
    cyc();
    iDATAIO_VALID = 1'b0;
    #1;
    chk("b2b_second_data", oNEXT_DATA, 32'h2222_2222);
    cyc();
    chk("b2b_req_count", req_cnt - base, 2);

    // Flush while a load is outstanding; the late response is swallowed.
    base = ret_cnt;
    drive_prev(1'b0, 32'h0000_0300, 32'h0, 2'd2, 2'd0, 4'hF);
    cyc();
    iPREV_VALID = 1'b0;
    cyc();
    iFLUSH = 1'b1;
    cyc();
    iFLUSH = 1'b0;
    for (int d = 1; d <= 3; d++) begin
      iDATAIO_VALID = (d == 3);
      iDATAIO_DATA = 32'h5555_5555;
      #1;
      chk("drain_next_valid", oNEXT_VALID, 0);
      chk("drain_fault", oFAULT, 0);
      chk("drain_prev_lock", oPREV_LOCK, 1);
      cyc();
    end
    iDATAIO_VALID = 1'b0;
    #1;
    chk("drain_idle_lock", oPREV_LOCK, 0);
    chk("drain_idle_fault", oFAULT, 0);
    chk("drain_no_retire", ret_cnt - base, 0);
    run_vec(vecs[7]);

    // Flush while the request is still being refused by memory.
    base = req_cnt;
    drive_prev(1'b1, 32'h0000_0400, 32'h0000_0077, 2'd0, 2'd0, 4'b0001);
    cyc();
    iPREV_VALID = 1'b0;
    iDATAIO_LOCK = 1'b1;
    iFLUSH = 1'b1;
    cyc();
    iDATAIO_LOCK = 1'b0;
    iFLUSH = 1'b0;
    #1;
    chk("flush_req_idle_req", oDATAIO_REQ, 0);
    chk("flush_req_idle_lock", oPREV_LOCK, 0);
    cyc();
    chk("flush_req_none_issued", req_cnt - base, 0);

    // Watchdog: load with no response.
    drive_prev(1'b0, 32'h0000_0500, 32'h0, 2'd2, 2'd0, 4'hF);
    cyc();
    iPREV_VALID = 1'b0;
    cyc();
    for (int w = 1; w <= 4; w++) begin
      #1;
      chk("wd_wait_fault", oFAULT, 0);
      chk("wd_wait_lock", oPREV_LOCK, 1);
      cyc();
    end
    chk("wd_fault_pulse", oFAULT, 1);
    chk("wd_idle_lock", oPREV_LOCK, 0);
    chk("wd_no_next", oNEXT_VALID, 0);
    cyc();
    chk("wd_fault_one_cycle", oFAULT, 0);
    base = ret_cnt;
    iDATAIO_VALID = 1'b1;
    iDATAIO_DATA = 32'h9999_9999;
    cyc();
    iDATAIO_VALID = 1'b0;
    #1;
    chk("wd_late_ignored", {oNEXT_VALID, oPREV_LOCK, oDATAIO_REQ}, 0);
    cyc();
    chk("wd_late_no_retire", ret_cnt - base, 0);

    // Misaligned word load.
`ifdef LDST_PIPE_MISALIGN_FAULT_EN
    base = req_cnt;
    drive_prev(1'b0, 32'h0000_3001, 32'h0, 2'd2, 2'd0, 4'hF);
    cyc();
    iPREV_VALID = 1'b0;
    #1;
    chk("mis_no_req", oDATAIO_REQ, 0);
    chk("mis_fault", oFAULT, 1);
    chk("mis_next_valid", oNEXT_VALID, 1);
    chk("mis_next_data", oNEXT_DATA, 0);
    cyc();
    chk("mis_fault_one_cycle", oFAULT, 0);
    chk("mis_idle", oNEXT_VALID, 0);
    chk("mis_req_count", req_cnt - base, 0);
`else
    begin
      vec_t mv;
      mv = '{1'b0, 32'h0000_3001, 32'h0, 2'd2, 2'd0, 4'b1111, 32'h0BAD_F00D, 1, 0, 32'h0000_3000, 32'h0BAD_F00D};
      run_vec(mv);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
